// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write scheduler.
// The WRAP state only exists when LCD_AUTOWRAP_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_AUTOWRAP_EN
    , ST_WRAP
`endif
  } state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ROW1_BASE     = 8'h40;

  localparam int DEF_T_SETUP     = 2;
  localparam int DEF_T_EPULSE    = 12;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_CMD_WAIT  = 2000;
  localparam int DEF_T_CLEAR_WAIT = 82000;
  localparam int DEF_COLS        = 16;

  // A state of t cycles loads t-1; zero still yields one cycle.
  function automatic int loadVal(input int t);
    return (t <= 1) ? 0 : t - 1;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module lcd_strobe_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_scheduler.sv
// Takes the HD44780 bus over from InitLCD and times every later write.
// Define LCD_AUTOWRAP_EN to insert a DDRAM address command on line wrap.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_EPULSE     = DEF_T_EPULSE,
  parameter int T_HOLD       = DEF_T_HOLD,
  parameter int T_CMD_WAIT   = DEF_T_CMD_WAIT,
  parameter int T_CLEAR_WAIT = DEF_T_CLEAR_WAIT,
  parameter int COLS         = DEF_COLS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_complete_flag,
  input  logic       RS_init_lcd,
  input  logic       RW_init_lcd,
  input  logic       E_init_lcd,
  input  logic [7:0] data_init_lcd,
  input  logic       req_valid,
  input  logic       req_is_cmd,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic [3:0] cursor_col,
  output logic       cursor_row
);

  localparam int MAX_T = maxInt(maxInt(maxInt(T_SETUP, T_EPULSE),
                                       maxInt(T_HOLD, T_CMD_WAIT)), T_CLEAR_WAIT);
  localparam int CW = (MAX_T < 2) ? 1 : $clog2(MAX_T);

  localparam logic [CW-1:0] LD_SETUP  = CW'(loadVal(T_SETUP));
  localparam logic [CW-1:0] LD_EPULSE = CW'(loadVal(T_EPULSE));
  localparam logic [CW-1:0] LD_HOLD   = CW'(loadVal(T_HOLD));
  localparam logic [CW-1:0] LD_CMD    = CW'(loadVal(T_CMD_WAIT));
  localparam logic [CW-1:0] LD_CLEAR  = CW'(loadVal(T_CLEAR_WAIT));
  localparam logic [3:0]    COL_LAST  = 4'(COLS - 1);

  state_e        state_q;
  logic          owner_q;
  logic          rs_q;
  logic          e_q;
  logic [7:0]    db_q;
  logic [3:0]    col_q, col_d;
  logic          row_q, row_d;
  logic          tLoad;
  logic [CW-1:0] tVal;
  logic          tDone;
  logic          accept;
  logic          longWait;
`ifdef LCD_AUTOWRAP_EN
  logic          wrap_d;
`endif

  assign accept   = req_valid && req_ready;
  assign longWait = !rs_q && ((db_q == CMD_CLEAR) || (db_q == CMD_HOME));

  lcd_strobe_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tLoad),
    .load_val_i (tVal),
    .done_o     (tDone)
  );

  // Cursor value to commit when the current transfer's WAIT ends.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
`ifdef LCD_AUTOWRAP_EN
    wrap_d = 1'b0;
`endif
    if (!rs_q) begin
      if (longWait) begin
        col_d = 4'd0;
        row_d = 1'b0;
      end else if (db_q[7]) begin
        col_d = db_q[3:0];
        row_d = db_q[6];
      end
    end else if (col_q == COL_LAST) begin
      col_d = 4'd0;
`ifdef LCD_AUTOWRAP_EN
      row_d  = ~row_q;
      wrap_d = 1'b1;
`endif
    end else begin
      col_d = col_q + 4'd1;
    end
  end

  // Timer reloads on the same edge that moves the FSM into a timed state.
  always_comb begin
    tLoad = 1'b0;
    tVal  = LD_SETUP;
    case (state_q)
      ST_IDLE:  tLoad = accept;
      ST_SETUP: begin tLoad = tDone; tVal = LD_EPULSE; end
      ST_EHIGH: begin tLoad = tDone; tVal = LD_HOLD; end
      ST_HOLD:  begin tLoad = tDone; tVal = longWait ? LD_CLEAR : LD_CMD; end
`ifdef LCD_AUTOWRAP_EN
      ST_WRAP:  tLoad = 1'b1;
`endif
      default:  tLoad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      db_q    <= 8'h00;
      col_q   <= 4'd0;
      row_q   <= 1'b0;
    end else begin
      owner_q <= owner_q | init_complete_flag;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rs_q    <= ~req_is_cmd;
            db_q    <= req_data;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tDone) begin
            e_q     <= 1'b1;
            state_q <= ST_EHIGH;
          end
        end
        ST_EHIGH: begin
          if (tDone) begin
            e_q     <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tDone) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tDone) begin
            col_q <= col_d;
            row_q <= row_d;
`ifdef LCD_AUTOWRAP_EN
            state_q <= wrap_d ? ST_WRAP : ST_IDLE;
`else
            state_q <= ST_IDLE;
`endif
          end
        end
`ifdef LCD_AUTOWRAP_EN
        // row_q already holds the new row committed at the end of WAIT.
        ST_WRAP: begin
          rs_q    <= 1'b0;
          db_q    <= CMD_SET_DDRAM | (row_q ? ROW1_BASE : 8'h00);
          state_q <= ST_SETUP;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pin mux: InitLCD until ownership, all-zero whenever reset is held.
  always_comb begin
    if (owner_q) begin
      LCD_RS = rs_q;
      LCD_RW = 1'b0;
      LCD_E  = e_q;
      LCD_DB = db_q;
    end else begin
      LCD_RS = RS_init_lcd;
      LCD_RW = RW_init_lcd;
      LCD_E  = E_init_lcd;
      LCD_DB = data_init_lcd;
    end
    if (!reset_n) begin
      LCD_RS = 1'b0;
      LCD_RW = 1'b0;
      LCD_E  = 1'b0;
      LCD_DB = 8'h00;
    end
  end

  assign req_ready  = owner_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
Owns the HD44780 pin bus after power-up and sequences all post-init traffic onto it. It passes InitLCD's RS/RW/E/data straight to the pins until init_complete_flag rises, then takes the bus over permanently. From that point it accepts character and command requests through a valid/ready handshake and generates setup, E-pulse, hold and execution-wait timing for each one. It also tracks the cursor and inserts line-wrap address commands for a 16x2 display.

Parameters:
T_SETUP, 2, cycles RS/DB stable before E rises
T_EPULSE, 12, cycles E held high
T_HOLD, 2, cycles RS/DB held after E falls
T_CMD_WAIT, 2000, execution wait for chars and ordinary commands (40 us at 50 MHz)
T_CLEAR_WAIT, 82000, execution wait after 0x01 or 0x02 (1.64 ms)
COLS, 16, visible columns per row (power of two, at most 16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
init_complete_flag  in  1  from InitLCD; high once init sequence done
RS_init_lcd  in  1  InitLCD RS
RW_init_lcd  in  1  InitLCD RW
E_init_lcd  in  1  InitLCD E
data_init_lcd  in  8  InitLCD data
req_valid  in  1  request present
req_is_cmd  in  1  1 = command (RS=0), 0 = character (RS=1)
req_data  in  8  command or character code
req_ready  out  1  scheduler can accept a request
busy  out  1  scheduler owns the bus and a transfer is in progress
LCD_RS  out  1  pin
LCD_RW  out  1  pin
LCD_E  out  1  pin
LCD_DB  out  8  pin
cursor_col  out  4  tracked column
cursor_row  out  1  tracked row

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- While reset_n=0, all outputs are 0: LCD_*, req_ready, busy, cursor. Ownership returns to InitLCD.
- Ownership:
  - A registered owner bit is set on the first clk edge that samples init_complete_flag=1.
  - The bit is sticky until reset. A later drop of init_complete_flag is ignored.
  - When owner=0, LCD_* are combinationally driven from the *_init_lcd inputs, and req_ready=0.
- Scheduler always drives LCD_RW=0. It never reads the busy flag; all timing is by fixed waits.
- FSM states: IDLE, SETUP, EHIGH, HOLD, WAIT, WRAP.
- IDLE:
  - req_ready=1 when owner=1. LCD_E=0.
  - An accept (req_valid && req_ready) latches is_cmd and data, then goes to SETUP.
  - The requester may change its inputs after accept.
- SETUP: T_SETUP cycles, LCD_RS = ~is_cmd, LCD_DB = data, LCD_E=0.
- EHIGH: T_EPULSE cycles, LCD_E=1.
- HOLD: T_HOLD cycles, LCD_E=0, RS/DB unchanged.
- WAIT:
  - Lasts T_CLEAR_WAIT cycles if the latched command is 0x01 or 0x02, else T_CMD_WAIT.
  - Then goes to WRAP if a wrap is pending, else IDLE.
- Latency: req_ready is low for exactly T_SETUP+T_EPULSE+T_HOLD+Twait cycles after the accept edge (no wrap).
- busy = 1 in every state except IDLE.
- Cursor updates happen at the end of WAIT:
  - Command 0x01 or 0x02: col=0, row=0.
  - Command with bit7 set: row=data[6], col=data[3:0].
  - Other commands: cursor unchanged.
  - Character: col+1. If the old col was COLS-1, set col=0, toggle row and flag a wrap as pending.
- WRAP: loads the internal command 0x80|(row?0x40:0x00) and runs SETUP..WAIT with T_CMD_WAIT. req_ready stays low throughout and is never asserted between the two transfers.
- Counters are sized for the largest wait, with no overflow. A zero-valued parameter means a 1-cycle state.
- Asserting reset mid-transfer forces LCD_E low asynchronously and aborts the transfer; there is no resume.

Optional Feature:
LCD_AUTOWRAP_EN
- Defined: behaviour above; WRAP inserts the address command.
- Undefined: WRAP state is absent and no address command is inserted. After a char at COLS-1, col wraps to 0 and row is unchanged.

Decomposition:
- Shared package lcd_pkg:
  - FSM state enum.
  - Constants CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_SET_DDRAM=0x80, ROW1_BASE=0x40.
  - Default timing values.
- One natural sub-module, lcd_strobe_timer:
  - Loadable down-counter with a done pulse.
  - Shared by SETUP, EHIGH, HOLD and WAIT.

Test Plan:
- Handover: init_complete_flag=0 with E_init_lcd toggling -> LCD_E mirrors it and req_ready=0. Raise the flag -> owner set next edge, req_ready=1. Drop the flag -> ownership unchanged.
- Char write: accept 'A' (0x41, is_cmd=0) -> LCD_RS=1, DB=0x41; E high for exactly 12 cycles starting 2 cycles after accept; req_ready back after 2016 cycles; col 0->1.
- Clear: accept cmd 0x01 from col 5, row 1 -> RS=0; req_ready low for 82016 cycles; cursor reads 0,0.
- Wrap: 16 chars on row 0 -> after the 16th, an auto transfer with DB=0xC0, RS=0; no req_ready between the two transfers; cursor reads row 1, col 0. Without LCD_AUTOWRAP_EN, no 0xC0 transfer and row stays 0.
- Set address: cmd 0xC7 -> cursor_row=1, cursor_col=7.
- Reset mid-EHIGH: pull reset_n low -> LCD_E=0 with no clk edge; all outputs 0. After release, the bus is back in InitLCD pass-through.
